koa_mult_scheduler: RTL and testbench
=====================================

KOA_MULT_SCHEDULER -- requirements
Module: koa_mult_scheduler

Interface
REQ-001 Parameter SW, 24: operand width in bits, matching the shared KOA multiplier.
REQ-002 Parameter LAT, 2: settle cycles allowed for the combinational KOA core before its result register loads; legal range 1..15.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req0_valid_i  in  1  requester 0 has an operand pair.
REQ-007 req0_ready_o  out  1  requester 0 pair accepted this cycle.
REQ-008 req0_a_i, req0_b_i  in  SW each  requester 0 operands.
REQ-009 req1_valid_i, req1_ready_o, req1_a_i, req1_b_i  same as REQ-006..008, for requester 1.
REQ-010 mul_a_o, mul_b_o  out  SW each  operands driven to the shared multiplier.
REQ-011 mul_load_o  out  1  load strobe to the multiplier result register (its load_b_i).
REQ-012 mul_result_i  in  2*SW  registered product from the multiplier.
REQ-013 res_valid_o  out  1  product available.
REQ-014 res_ready_i  in  1  consumer takes the product.
REQ-015 res_id_o  out  1  requester that owns the product.
REQ-016 res_data_o  out  2*SW  product; equals mul_result_i.
REQ-017 busy_o  out  1  high in any state other than IDLE.
REQ-018 perf_cnt_o  out  16  completed-operation count; see Configuration.

Function
REQ-019 The FSM SHALL have four states: IDLE, CALC, LOAD and DONE.
REQ-020 IDLE: if any valid is high, the block SHALL grant exactly one requester and assert its ready_o combinationally in that cycle.
REQ-021 On the same edge it SHALL capture that requester's operands into mul_a_o/mul_b_o and its index into res_id_o, load the counter with LAT, and move to CALC.
REQ-022 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not granted last. The last-grant flag resets to 1, so req0 wins the first tie.
REQ-023 A single valid requester SHALL be granted regardless of the last-grant flag.
REQ-024 Both ready outputs SHALL never be high in the same cycle, and ready SHALL be low outside IDLE.
REQ-025 CALC: the counter SHALL decrement each cycle; the FSM moves to LOAD when the counter reaches 1, giving exactly LAT cycles in CALC.
REQ-026 LOAD: mul_load_o SHALL be 1 for exactly one cycle, then the FSM moves to DONE. mul_load_o SHALL be 0 in all other states.
REQ-027 DONE: res_valid_o SHALL be 1. When res_ready_i is 1, the FSM returns to IDLE on that edge.
REQ-028 A new request SHALL NOT be accepted in the DONE exit cycle; the earliest next acceptance is the following cycle.
REQ-029 res_valid_o SHALL first assert LAT+2 cycles after the acceptance edge.
REQ-030 mul_a_o, mul_b_o and res_id_o SHALL hold stable from acceptance until the next acceptance.
REQ-031 While res_valid_o is high and res_ready_i is low, res_valid_o, res_id_o and res_data_o SHALL hold.
REQ-032 Product width SHALL be 2*SW with no truncation.
REQ-033 Requester valid dropping before a grant SHALL be legal and ignored.

Reset
REQ-034 On rst=1 at a clock edge, the FSM SHALL enter IDLE, from any state including mid-CALC or LOAD.
REQ-035 On that same reset edge, mul_a_o, mul_b_o, res_id_o, counter, mul_load_o, res_valid_o, busy_o and perf_cnt_o SHALL be set to 0, and last-grant to 1.
REQ-036 Any in-flight operation SHALL be discarded with no res_valid_o.
REQ-037 res_data_o SHALL read 0 after reset, since the multiplier result register shares rst.
REQ-038 Ready outputs SHALL be 0 while rst=1.

Configuration
REQ-039 Macro KOA_SCHED_PERFCNT_EN, when defined: perf_cnt_o SHALL increment by 1 on every DONE handshake (res_valid_o and res_ready_i both 1), wrapping from 0xFFFF to 0x0000.
REQ-040 When KOA_SCHED_PERFCNT_EN is undefined, perf_cnt_o SHALL be constant 0 and no counter register is built.

Verification (SW=24, LAT=2, res_ready_i=1 unless stated)
REQ-041 req0 A=0x000003, B=0x000005 valid at cycle 0 -> req0_ready_o=1 at cycle 0; mul_load_o=1 at cycle 3; res_valid_o=1 at cycle 4 with res_data_o=0x00000000000F and res_id_o=0.
REQ-042 Both requesters valid continuously from reset, req0 0x000002*0x000003 and req1 0x000004*0x000005 -> results alternate, id 0 (0x6) then id 1 (0x14), then id 0 again.
REQ-043 res_ready_i held low 5 cycles in DONE -> res_valid_o, res_data_o and res_id_o stable, both ready outputs low, busy_o=1; completes on the cycle ready rises.
REQ-044 0xFFFFFF*0xFFFFFF -> res_data_o=0xFFFFFE000001.
REQ-045 rst pulsed for one cycle during CALC -> next cycle all outputs 0 with the FSM in IDLE and no result emitted; a following request 0x000007*0x000007 yields 0x31 with normal latency.
REQ-046 Three completed operations -> perf_cnt_o=3 with KOA_SCHED_PERFCNT_EN defined, 0 without.

Source files
------------

// File: rtl/koa_mult_scheduler.sv
// Round-robin two-requester front end for a shared combinational KOA multiplier.
// Define KOA_SCHED_PERFCNT_EN to build the completed-operation counter on perf_cnt_o.
module koa_mult_scheduler #(
    parameter int SW  = 24,
    parameter int LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [SW-1:0]   req0_a_i,
    input  logic [SW-1:0]   req0_b_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [SW-1:0]   req1_a_i,
    input  logic [SW-1:0]   req1_b_i,
    output logic [SW-1:0]   mul_a_o,
    output logic [SW-1:0]   mul_b_o,
    output logic            mul_load_o,
    input  logic [2*SW-1:0] mul_result_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic            res_id_o,
    output logic [2*SW-1:0] res_data_o,
    output logic            busy_o,
    output logic [15:0]     perf_cnt_o
);

    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, CALC, LOAD, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] a_q, a_d;
    logic [SW-1:0] b_q, b_d;
    logic          id_q, id_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          any_vld;
    logic          gnt_id;
    logic          accept;

    // On a tie the requester not granted last wins; a lone requester always wins.
    always_comb begin
        any_vld = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i)
            gnt_id = ~last_q;
        else
            gnt_id = req1_valid_i;
        accept = (state_q == IDLE) && any_vld && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_vld) state_d = CALC;
            CALC:    if (cnt_q == CW'(1)) state_d = LOAD;
            LOAD:    state_d = DONE;
            DONE:    if (res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        mul_load_o   = 1'b0;
        res_valid_o  = 1'b0;
        busy_o       = 1'b1;
        case (state_q)
            IDLE: begin
                busy_o       = 1'b0;
                req0_ready_o = accept && !gnt_id;
                req1_ready_o = accept && gnt_id;
            end
            LOAD:    mul_load_o  = 1'b1;
            DONE:    res_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Operands and owner id stay frozen from acceptance until the next acceptance.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        id_d   = id_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (accept) begin
            a_d    = gnt_id ? req1_a_i : req0_a_i;
            b_d    = gnt_id ? req1_b_i : req0_b_i;
            id_d   = gnt_id;
            last_d = gnt_id;
            cnt_d  = CW'(LAT);
        end else if (state_q == CALC) begin
            cnt_d  = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= 1'b0;
            last_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            id_q   <= id_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    assign mul_a_o    = a_q;
    assign mul_b_o    = b_q;
    assign res_id_o   = id_q;
    assign res_data_o = mul_result_i;

`ifdef KOA_SCHED_PERFCNT_EN
    logic [15:0] perf_q, perf_d;
    logic        res_hs;

    always_comb begin
        res_hs = res_valid_o && res_ready_i;
        perf_d = res_hs ? perf_q + 16'd1 : perf_q;
    end

    always_ff @(posedge clk) begin
        if (rst)
            perf_q <= '0;
        else
            perf_q <= perf_d;
    end

    assign perf_cnt_o = perf_q;
`else
    assign perf_cnt_o = 16'd0;
`endif

    a_one_ready: assert property (@(posedge clk) !(req0_ready_o && req1_ready_o));
    a_load_pulse: assert property (@(posedge clk) disable iff (rst) mul_load_o |=> !mul_load_o);

endmodule

// File: tb/tb_koa_mult_scheduler.sv
// Scoreboard bench for koa_mult_scheduler with a behavioural registered multiplier.
module tb_koa_mult_scheduler;

    localparam int SW  = 24;
    localparam int LAT = 2;

    typedef struct packed {
        logic          id;
        logic [47:0]   data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid_i, req0_ready_o;
    logic [SW-1:0]   req0_a_i, req0_b_i;
    logic            req1_valid_i, req1_ready_o;
    logic [SW-1:0]   req1_a_i, req1_b_i;
    logic [SW-1:0]   mul_a_o, mul_b_o;
    logic            mul_load_o;
    logic [2*SW-1:0] mul_result_i;
    logic            res_valid_o, res_ready_i, res_id_o;
    logic [2*SW-1:0] res_data_o;
    logic            busy_o;
    logic [15:0]     perf_cnt_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   acc_cnt  = 0;
    logic vld_prev = 1'b0;
    exp_t exp_q[$];

    koa_mult_scheduler #(.SW(SW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
        .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_load_o(mul_load_o),
        .mul_result_i(mul_result_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_id_o(res_id_o), .res_data_o(res_data_o),
        .busy_o(busy_o), .perf_cnt_o(perf_cnt_o)
    );

    always #5 clk = ~clk;

    // Shared multiplier result register, reset together with the scheduler.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst)
            mul_result_i <= '0;
        else if (mul_load_o)
            mul_result_i <= 48'(mul_a_o) * 48'(mul_b_o);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: grant exclusivity, acceptance-to-valid latency, result scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            vld_prev = 1'b0;
        end else begin
            if (req0_ready_o && req1_ready_o)
                check("ready_exclusive", 64'(req1_ready_o), 64'd0);
            if ((req0_ready_o && req0_valid_i) || (req1_ready_o && req1_valid_i)) begin
                acc_cyc = cyc;
                acc_cnt++;
            end
            if (res_valid_o && !vld_prev)
                check("valid_latency", 64'(cyc - acc_cyc), 64'(LAT + 2));
            if (res_valid_o && res_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(res_data_o), 64'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_id", 64'(res_id_o), 64'(e.id));
                    check("res_data", 64'(res_data_o), 64'(e.data));
                end
            end
            vld_prev = res_valid_o;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy_o || exp_q.size() != 0) && n < 100);
        check("idle_within_bound", 64'(busy_o || exp_q.size() != 0), 64'd0);
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_cnt < target && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("accepts_within_bound", 64'(acc_cnt >= target), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid_i = 1'b1; req0_a_i = '0; req0_b_i = '0;
        req1_valid_i = 1'b1; req1_a_i = '0; req1_b_i = '0;
        res_ready_i = 1'b1;

        // Reset: ready must stay low even with valid requests.
        repeat (2) @(negedge clk);
        check("rst_ready0", 64'(req0_ready_o), 64'd0);
        check("rst_ready1", 64'(req1_ready_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_res_valid", 64'(res_valid_o), 64'd0);
        check("rst_mul_a", 64'(mul_a_o), 64'd0);
        check("rst_mul_b", 64'(mul_b_o), 64'd0);
        check("rst_res_id", 64'(res_id_o), 64'd0);
        check("rst_mul_load", 64'(mul_load_o), 64'd0);
        check("rst_res_data", 64'(res_data_o), 64'd0);
        check("rst_perf", 64'(perf_cnt_o), 64'd0);

        // 3 * 5, cycle-by-cycle timing.
        @(posedge clk); #1;
        req0_a_i = 24'h3; req0_b_i = 24'h5; req0_valid_i = 1'b1;
        exp_q.push_back('{id: 1'b0, data: 48'hF});
        @(negedge clk);
        check("t1_ready0", 64'(req0_ready_o), 64'd1);
        check("t1_ready1", 64'(req1_ready_o), 64'd0);
        @(posedge clk); #1;
        req0_valid_i = 1'b0;
        @(negedge clk);
        check("t1_busy", 64'(busy_o), 64'd1);
        check("t1_mul_a", 64'(mul_a_o), 64'h3);
        check("t1_mul_b", 64'(mul_b_o), 64'h5);
        check("t1_load_c1", 64'(mul_load_o), 64'd0);
        @(negedge clk);
        check("t1_load_c2", 64'(mul_load_o), 64'd0);
        @(negedge clk);
        check("t1_load_c3", 64'(mul_load_o), 64'd1);
        check("t1_valid_c3", 64'(res_valid_o), 64'd0);
        @(negedge clk);
        check("t1_valid_c4", 64'(res_valid_o), 64'd1);
        check("t1_load_c4", 64'(mul_load_o), 64'd0);
        wait_idle();

        // Round-robin from reset: id0, id1, id0.
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        req0_a_i = 24'h2; req0_b_i = 24'h3; req0_valid_i = 1'b1;
        req1_a_i = 24'h4; req1_b_i = 24'h5; req1_valid_i = 1'b1;
        exp_q.push_back('{id: 1'b0, data: 48'h6});
        exp_q.push_back('{id: 1'b1, data: 48'h14});
        exp_q.push_back('{id: 1'b0, data: 48'h6});
        wait_acc(acc_cnt + 3);
        #1; req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        wait_idle();
`ifdef KOA_SCHED_PERFCNT_EN
        check("perf_after_3", 64'(perf_cnt_o), 64'd3);
`else
        check("perf_after_3", 64'(perf_cnt_o), 64'd0);
`endif

        // Lone req0 after an id0 grant, max operands, consumer stalls 5 cycles.
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        req0_a_i = 24'hFFFFFF; req0_b_i = 24'hFFFFFF; req0_valid_i = 1'b1;
        exp_q.push_back('{id: 1'b0, data: 48'hFFFFFE000001});
        @(negedge clk);
        check("lone_ready0", 64'(req0_ready_o), 64'd1);
        @(posedge clk); #1;
        req0_valid_i = 1'b0;
        req1_a_i = 24'h10; req1_b_i = 24'h10; req1_valid_i = 1'b1;
        for (int n = 0; n < 20 && !res_valid_o; n++) @(negedge clk);
        check("stall_reached_done", 64'(res_valid_o), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 64'(res_valid_o), 64'd1);
            check("stall_data", 64'(res_data_o), 64'hFFFFFE000001);
            check("stall_id", 64'(res_id_o), 64'd0);
            check("stall_ready0", 64'(req0_ready_o), 64'd0);
            check("stall_ready1", 64'(req1_ready_o), 64'd0);
            check("stall_busy", 64'(busy_o), 64'd1);
            check("stall_mul_a", 64'(mul_a_o), 64'hFFFFFF);
            @(negedge clk);
        end
        @(posedge clk); #1;
        res_ready_i = 1'b1;
        exp_q.push_back('{id: 1'b1, data: 48'h100});
        @(negedge clk);
        check("exit_cycle_ready1", 64'(req1_ready_o), 64'd0);
        @(negedge clk);
        check("after_exit_ready1", 64'(req1_ready_o), 64'd1);
        @(posedge clk); #1;
        req1_valid_i = 1'b0;
        wait_idle();

        // Reset mid-CALC discards the operation.
        @(posedge clk); #1;
        req0_a_i = 24'h9; req0_b_i = 24'h9; req0_valid_i = 1'b1;
        @(posedge clk); #1;
        req0_valid_i = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_mul_a", 64'(mul_a_o), 64'd0);
        check("abort_mul_b", 64'(mul_b_o), 64'd0);
        check("abort_res_id", 64'(res_id_o), 64'd0);
        check("abort_res_data", 64'(res_data_o), 64'd0);
        check("abort_perf", 64'(perf_cnt_o), 64'd0);
        for (int k = 0; k < 6; k++) begin
            check("abort_no_valid", 64'(res_valid_o), 64'd0);
            check("abort_no_load", 64'(mul_load_o), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        req0_a_i = 24'h7; req0_b_i = 24'h7; req0_valid_i = 1'b1;
        exp_q.push_back('{id: 1'b0, data: 48'h31});
        @(negedge clk);
        check("post_abort_ready0", 64'(req0_ready_o), 64'd1);
        @(posedge clk); #1;
        req0_valid_i = 1'b0;
        wait_idle();
`ifdef KOA_SCHED_PERFCNT_EN
        check("perf_after_abort", 64'(perf_cnt_o), 64'd1);
`else
        check("perf_after_abort", 64'(perf_cnt_o), 64'd0);
`endif

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
